// File: rtl/pre_if_stage.sv
// pre_if_stage: pre-fetch stage that sits directly upstream of IF.
//
// It owns the fetch PC and picks the next fetch address from, in priority
// order: a flush redirect from WB, a buffered flush, a branch redirect from ID,
// a buffered branch, and otherwise the sequential PC. It starts the
// synchronous instruction SRAM read; the data returns one cycle later,
// lined up with the IF register.
//
// Handshake: a fetch is offered to IF whenever preIF_to_IF_valid=1. It is
// transferred ("fire") on a rising edge where preIF_to_IF_valid=1 and
// IF_allow_in=1. Until that edge the offered PC stays stable unless a
// higher-priority redirect replaces it.
//
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   IF_allow_in         - IF accepts the offered fetch at the next edge
//   br_taken/br_target  - taken branch/jump resolved in ID
//   flush/flush_target  - exception/ertn redirect from WB (highest priority)
//   preIF_to_IF_*       - valid / pc / address-error offered to IF
//   inst_sram_*         - read-only port to the instruction SRAM
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        preIF_to_IF_valid,
    output logic [31:0] preIF_to_IF_pc,
    output logic        preIF_to_IF_adef,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    // Holds RESET_PC-4 so the sequential path offers RESET_PC first.
    localparam logic [31:0] SEQ_PC_RESET = RESET_PC - 32'd4;

    logic        pre_valid_q,        pre_valid_d;
    logic [31:0] seq_pc_q,           seq_pc_d;
    logic        br_buf_valid_q,     br_buf_valid_d;
    logic [31:0] br_buf_target_q,    br_buf_target_d;
    logic        flush_buf_valid_q,  flush_buf_valid_d;
    logic [31:0] flush_buf_target_q, flush_buf_target_d;

    logic [31:0] nextpc;
    logic        fire;
    logic        adef;

    // A buffered flush outranks a live branch: once WB has redirected, any
    // branch ID reports is from the wrong path.
    always_comb begin
        if (flush) begin
            nextpc = flush_target;
        end else if (flush_buf_valid_q) begin
            nextpc = flush_buf_target_q;
        end else if (br_taken) begin
            nextpc = br_target;
        end else if (br_buf_valid_q) begin
            nextpc = br_buf_target_q;
        end else begin
            nextpc = seq_pc_q + 32'd4;
        end
    end

    assign fire = pre_valid_q & IF_allow_in;
    assign adef = |nextpc[1:0];

    assign preIF_to_IF_valid = pre_valid_q;
    assign preIF_to_IF_pc    = nextpc;
    assign preIF_to_IF_adef  = adef;
    // A misaligned PC still goes to IF, flagged with adef, but never reaches SRAM.
    assign inst_sram_en      = fire & ~adef;
    assign inst_sram_we      = 4'b0000;
    assign inst_sram_addr    = nextpc;
    assign inst_sram_wdata   = 32'h0;

    always_comb begin
        pre_valid_d        = 1'b1;
        seq_pc_d           = seq_pc_q;
        br_buf_valid_d     = br_buf_valid_q;
        br_buf_target_d    = br_buf_target_q;
        flush_buf_valid_d  = flush_buf_valid_q;
        flush_buf_target_d = flush_buf_target_q;

        if (fire) begin
            // The offered PC (including any redirect) has been consumed.
            seq_pc_d          = nextpc;
            br_buf_valid_d    = 1'b0;
            flush_buf_valid_d = 1'b0;
        end else if (flush) begin
            // A flush discards any buffered branch.
            flush_buf_valid_d  = 1'b1;
            flush_buf_target_d = flush_target;
            br_buf_valid_d     = 1'b0;
        end else if (br_taken && !flush_buf_valid_q) begin
            // A newer branch overwrites an older buffered one.
            br_buf_valid_d  = 1'b1;
            br_buf_target_d = br_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_valid_q        <= 1'b0;
            seq_pc_q           <= SEQ_PC_RESET;
            br_buf_valid_q     <= 1'b0;
            br_buf_target_q    <= 32'h0;
            flush_buf_valid_q  <= 1'b0;
            flush_buf_target_q <= 32'h0;
        end else begin
            pre_valid_q        <= pre_valid_d;
            seq_pc_q           <= seq_pc_d;
            br_buf_valid_q     <= br_buf_valid_d;
            br_buf_target_q    <= br_buf_target_d;
            flush_buf_valid_q  <= flush_buf_valid_d;
            flush_buf_target_q <= flush_buf_target_d;
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Testbench for pre_if_stage. Each cycle's stimulus pushes the expected
// {valid, en, adef, pc} onto exp_q; a negedge monitor pops the entry and
// compares it against the DUT outputs.
module tb_pre_if_stage;

    logic        clk;
    logic        reset;
    logic        IF_allow_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_target;
    logic        preIF_to_IF_valid;
    logic [31:0] preIF_to_IF_pc;
    logic        preIF_to_IF_adef;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int n_tests;
    int n_fail;

    logic [34:0] exp_q[$];
    logic [31:0] seq_m;

    pre_if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk               (clk),
        .reset             (reset),
        .IF_allow_in       (IF_allow_in),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .flush             (flush),
        .flush_target      (flush_target),
        .preIF_to_IF_valid (preIF_to_IF_valid),
        .preIF_to_IF_pc    (preIF_to_IF_pc),
        .preIF_to_IF_adef  (preIF_to_IF_adef),
        .inst_sram_en      (inst_sram_en),
        .inst_sram_we      (inst_sram_we),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] pk(input logic v, input logic en, input logic ad, input logic [31:0] pc);
        return {v, en, ad, pc};
    endfunction

    function automatic logic [34:0] observed();
        return {preIF_to_IF_valid, inst_sram_en, preIF_to_IF_adef, preIF_to_IF_pc};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [34:0] e;
            e = exp_q.pop_front();
            check_eq("outputs", {29'b0, observed()}, {29'b0, e});
            check_eq("addr_eq_pc", {32'b0, inst_sram_addr}, {32'b0, e[31:0]});
            check_eq("we_wdata", {28'b0, inst_sram_we, inst_sram_wdata}, 64'h0);
        end
    end

    // driver: apply one cycle of inputs with the outputs expected in that cycle
    task automatic step(input logic allow, input logic br, input logic [31:0] bt,
                        input logic fl, input logic [31:0] ft, input logic [34:0] exp);
        IF_allow_in  = allow;
        br_taken     = br;
        br_target    = bt;
        flush        = fl;
        flush_target = ft;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic allow, input logic [34:0] exp);
        step(allow, 1'b0, 32'h0, 1'b0, 32'h0, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        IF_allow_in = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        flush = 1'b0;
        flush_target = 32'h0;

        #1;
        check_eq("reset_outputs", {29'b0, observed()}, {29'b0, pk(0, 0, 0, 32'h1c000000)});
        check_eq("reset_we_wdata", {28'b0, inst_sram_we, inst_sram_wdata}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // first fetch one cycle after release, then sequential
        idle(1, pk(0, 0, 0, 32'h1c000000));
        idle(1, pk(1, 1, 0, 32'h1c000000));
        idle(1, pk(1, 1, 0, 32'h1c000004));
        idle(1, pk(1, 1, 0, 32'h1c000008));
        idle(1, pk(1, 1, 0, 32'h1c00000c));
        idle(1, pk(1, 1, 0, 32'h1c000010));

        // stall holds the offered PC
        repeat (3) idle(0, pk(1, 0, 0, 32'h1c000014));
        idle(1, pk(1, 1, 0, 32'h1c000014));

        // branch while stalled is buffered and offered on release
        step(0, 1, 32'h1c000100, 0, 32'h0, pk(1, 0, 0, 32'h1c000100));
        idle(0, pk(1, 0, 0, 32'h1c000100));
        idle(1, pk(1, 1, 0, 32'h1c000100));
        idle(1, pk(1, 1, 0, 32'h1c000104));

        // flush over a buffered branch; a later wrong-path branch is ignored
        step(0, 1, 32'h1c000100, 0, 32'h0, pk(1, 0, 0, 32'h1c000100));
        step(0, 0, 32'h0, 1, 32'h1c008000, pk(1, 0, 0, 32'h1c008000));
        step(0, 1, 32'h1c000200, 0, 32'h0, pk(1, 0, 0, 32'h1c008000));
        idle(1, pk(1, 1, 0, 32'h1c008000));
        idle(1, pk(1, 1, 0, 32'h1c008004));

        // misaligned branch target: offered with adef, SRAM not enabled
        step(1, 1, 32'h1c000102, 0, 32'h0, pk(1, 0, 1, 32'h1c000102));
        step(1, 1, 32'h1c000200, 0, 32'h0, pk(1, 1, 0, 32'h1c000200));
        idle(1, pk(1, 1, 0, 32'h1c000204));

        // flush beats a same-cycle branch and is offered immediately
        step(1, 1, 32'h1c000300, 1, 32'h1c009000, pk(1, 1, 0, 32'h1c009000));
        idle(1, pk(1, 1, 0, 32'h1c009004));

        // sequential PC wraps modulo 2^32
        step(1, 0, 32'h0, 1, 32'hfffffffc, pk(1, 1, 0, 32'hfffffffc));
        idle(1, pk(1, 1, 0, 32'h00000000));

        // random stalls on the sequential path
        seq_m = 32'h00000000;
        for (int i = 0; i < 40; i++) begin
            logic a;
            a = 1'($urandom_range(0, 1));
            idle(a, pk(1, a, 0, seq_m + 32'd4));
            if (a) seq_m = seq_m + 32'd4;
        end

        // asynchronous reset mid-stall with a buffered branch
        step(0, 1, 32'h1c000100, 0, 32'h0, pk(1, 0, 0, 32'h1c000100));
        IF_allow_in = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset", {29'b0, observed()}, {29'b0, pk(0, 0, 0, 32'h1c000000)});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1, pk(0, 0, 0, 32'h1c000000));
        idle(1, pk(1, 1, 0, 32'h1c000000));
        idle(1, pk(1, 1, 0, 32'h1c000004));

        @(negedge clk);
        #1;
        check_eq("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-fetch stage directly upstream of the IF stage in the 5-stage in-order CPU.
- Owns the fetch PC and computes nextpc.
- Issues the synchronous inst SRAM read and hands {valid, pc, adef} to IF under the valid/allow_in handshake.
- Instruction data returns from the SRAM one cycle later, aligned with the IF register.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetched instruction after reset.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
IF_allow_in  input  1  IF will latch preIF outputs at the next edge
br_taken  input  1  ID resolved a taken branch/jump this cycle
br_target  input  32  branch/jump target, valid with br_taken
flush  input  1  exception/ertn redirect from WB, highest priority
flush_target  input  32  redirect PC, valid with flush
preIF_to_IF_valid  output  1  a fetch is offered to IF this cycle
preIF_to_IF_pc  output  32  PC of the offered fetch (= nextpc)
preIF_to_IF_adef  output  1  offered PC is misaligned (nextpc[1:0]!=0)
inst_sram_en  output  1  SRAM read enable
inst_sram_we  output  4  always 4'b0
inst_sram_addr  output  32  SRAM address (= nextpc)
inst_sram_wdata  output  32  always 32'b0

Behaviour:
- State registers:
  - pre_valid: reset 0; set to 1 on the first edge after reset deasserts and stays 1.
  - seq_pc: reset RESET_PC-4 (0x1bfffffc); holds the PC last accepted by IF.
  - br_buf_valid: reset 0.
  - br_buf_target: reset 0.
  - flush_buf_valid: reset 0.
  - flush_buf_target: reset 0.
- nextpc mux, strict priority:
  1. flush ? flush_target
  2. flush_buf_valid ? flush_buf_target
  3. br_taken ? br_target
  4. br_buf_valid ? br_buf_target
  5. seq_pc+4 (32-bit add, wraps modulo 2^32, no carry out)
- Outputs (combinational):
  - fire = pre_valid & IF_allow_in.
  - preIF_to_IF_valid = pre_valid.
  - preIF_to_IF_pc = inst_sram_addr = nextpc.
  - adef = |nextpc[1:0].
  - inst_sram_en = fire & ~adef. A misaligned PC is never sent to SRAM; IF still receives valid=1 with adef=1.
- Reset values:
  - preIF_to_IF_valid=0, inst_sram_en=0, we=0, wdata=0.
  - pc/addr = RESET_PC, adef=0.
- On fire (edge): seq_pc<=nextpc; br_buf_valid<=0; flush_buf_valid<=0.
- On ~fire (edge):
  - flush: flush_buf_valid<=1, flush_buf_target<=flush_target, br_buf_valid<=0. The flush discards any buffered branch.
  - br_taken & ~flush & ~flush_buf_valid: br_buf_valid<=1, br_buf_target<=br_target. A newer branch overwrites an older buffered one.
  - br_taken while flush_buf_valid=1: ignored (wrong-path branch).
- Latency:
  - Redirect with IF_allow_in=1: target is offered in the same cycle.
  - Redirect while stalled: target is held and offered in the first cycle IF_allow_in=1.
- First fetch: one cycle after reset deasserts, at RESET_PC.
- Reset asserted mid-stall: all buffers cleared immediately (async); after release, fetch restarts at RESET_PC.
- Wrong-path squash of the instruction already in IF is IF/ID responsibility, not this block's.

Test Plan:
- Reset high 3 cycles, release, IF_allow_in=1 -> en=0 and addr=0x1c000000 in the cycle after release, then en=1 with addr 0x1c000000, 0x1c000004, 0x1c000008 on successive cycles.
- Steady fetch at 0x1c000010, IF_allow_in=0 for 3 cycles -> valid=1, en=0, addr held at 0x1c000014; allow returns -> en=1 with addr 0x1c000014.
- IF_allow_in=0, br_taken=1 with br_target=0x1c000100 for 1 cycle, allow high 2 cycles later -> addr=0x1c000100 on release, then 0x1c000104.
- Stalled with branch 0x1c000100 buffered, flush=1 with flush_target=0x1c008000, then a wrong-path br_taken to 0x1c000200 -> on release addr=0x1c008000, then 0x1c008004 (branch discarded).
- br_taken with br_target=0x1c000102, IF_allow_in=1 -> preIF_to_IF_valid=1, adef=1, pc=0x1c000102, inst_sram_en=0.
- Reset asserted asynchronously mid-stall with br_buf_valid=1 -> outputs take reset values without a clock edge; after release fetch resumes at 0x1c000000.
